// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and helpers for the pipelined carry-lookahead adder
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_GROUP = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // One pipeline stage per lookahead slice; a degenerate GROUP is caught by the top's config check.
    function automatic int stage_count(input int width, input int group);
        if (group < 1) begin
            return 1;
        end
        return width / group;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// rtl/pipelined_cla_adder_cla_group.sv - combinational GROUP-bit carry-lookahead slice
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [GROUP-1:0] gen;
    logic [GROUP-1:0] prop;
    logic [GROUP:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every carry is a flat OR of products: g[i] | p[i]g[i-1] | ... | p[i..0]cin, no ripple chain.
    always_comb begin
        logic chain;
        chain    = 1'b0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            carry[i+1] = gen[i];
            chain      = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry[i+1] = carry[i+1] | (chain & gen[j]);
                chain      = chain & prop[j];
            end
            carry[i+1] = carry[i+1] | (chain & cin);
        end
    end

    assign sum      = prop ^ carry[GROUP-1:0];
    assign cout     = carry[GROUP];
    assign c_msb_in = carry[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined add/subtract, one lookahead slice resolved per stage
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int S = stage_count(WIDTH, GROUP);

    if ((GROUP < 1) ? 1'b1 : ((WIDTH % GROUP) != 0)) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end

    // The whole pipe moves as one; a stalled output freezes every stage, bubbles included.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < S; k++) begin : g_stage
        // Operand bits still to be consumed when entering stage k, and result bits known after it.
        localparam int IW = WIDTH - k * GROUP;
        localparam int RW = (k + 1) * GROUP;

        logic [IW-1:0]    op_a;
        logic [IW-1:0]    op_b;
        logic             cy_in;
        logic             v_in;
        logic [GROUP-1:0] slice_sum;
        logic             slice_cout;
        logic             slice_cmsb;
        logic [RW-1:0]    res_d;
        logic [RW-1:0]    res_q;
        logic             cy_q;
        logic             vld_q;

        if (k == 0) begin : g_entry
            assign op_a  = a;
            assign op_b  = (sub == OP_SUB) ? ~b : b;
            assign cy_in = (sub == OP_ADD) ? c_in : 1'b1;
            assign v_in  = in_valid;
            assign res_d = slice_sum;
        end else begin : g_chain
            assign op_a  = g_stage[k-1].g_fwd.a_q;
            assign op_b  = g_stage[k-1].g_fwd.b_q;
            assign cy_in = g_stage[k-1].cy_q;
            assign v_in  = g_stage[k-1].vld_q;
            assign res_d = {slice_sum, g_stage[k-1].res_q};
        end

        cla_group #(.GROUP(GROUP)) u_cla (
            .a        (op_a[GROUP-1:0]),
            .b        (op_b[GROUP-1:0]),
            .cin      (cy_in),
            .sum      (slice_sum),
            .cout     (slice_cout),
            .c_msb_in (slice_cmsb)
        );

        // Stage register: accumulated result slices, the slice carry-out and the valid bit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_q <= '0;
                cy_q  <= 1'b0;
                vld_q <= 1'b0;
            end else if (advance) begin
                res_q <= res_d;
                cy_q  <= slice_cout;
                vld_q <= v_in;
            end
        end

        if (k < S - 1) begin : g_fwd
            logic [IW-GROUP-1:0] a_q;
            logic [IW-GROUP-1:0] b_q;

            // Carry forward only the operand slices later stages have yet to add.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= op_a[IW-1:GROUP];
                    b_q <= op_b[IW-1:GROUP];
                end
            end
        end else begin : g_last
            logic cmsb_q;
            logic zero_q;

            // Output stage also keeps the carry into the MSB and the zero test of the full sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmsb_q <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    cmsb_q <= slice_cmsb;
                    zero_q <= (res_d == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[S-1].vld_q;
    assign sum       = g_stage[S-1].res_q;
    assign c_out     = g_stage[S-1].cy_q;
    assign ovf       = g_stage[S-1].g_last.cmsb_q ^ g_stage[S-1].cy_q;
    assign zero      = g_stage[S-1].g_last.zero_q;

endmodule
